// File: rtl/alu_op_sequencer.sv
// Multi-cycle ADD/SUB/NEG/MUL sequencer around one shared external adder.
// Operands are taken on an input handshake; the result is offered on an output handshake.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEGB,
        S_ADD,
        S_MUL,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] t_r;
    logic             c1_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic             fin;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_hi;
    logic             fin_c;
    logic             fin_v;
    logic             fin_z;
    logic             fin_n;

    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] mul_q_nx;

    // One shift-add step: the adder carry-out lands in the ACC msb.
    assign mul_acc_nx = {add_cout, add_sum[WIDTH-1:1]};
    assign mul_q_nx   = {add_sum[0], q[WIDTH-1:1]};

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        fin      = 1'b0;
        fin_res  = '0;
        fin_hi   = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    unique case (op)
                        OP_ADD: state_nx = S_ADD;
                        OP_SUB: state_nx = S_NEGB;
                        OP_NEG: state_nx = S_NEGB;
                        OP_MUL: state_nx = S_MUL;
                    endcase
                end
            end
            S_NEGB: begin
                add_a   = ~b_r;
                add_cin = 1'b1;
                if (op_r == OP_NEG) begin
                    fin      = 1'b1;
                    fin_res  = add_sum;
                    fin_c    = add_cout;
                    fin_v    = (b_r == MSB_ONLY);
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_ADD;
                end
            end
            S_ADD: begin
                add_a    = a_r;
                add_b    = (op_r == OP_ADD) ? b_r : t_r;
                fin      = 1'b1;
                fin_res  = add_sum;
                state_nx = S_DONE;
                if (op_r == OP_ADD) begin
                    fin_c = add_cout;
                    fin_v = (a_r[WIDTH-1] == b_r[WIDTH-1])
                          && (add_sum[WIDTH-1] != a_r[WIDTH-1]);
                end else begin
                    // Carry of ~B+1 covers B==0, where the ADD pass cannot carry.
                    fin_c = c1_r | add_cout;
                    fin_v = (a_r[WIDTH-1] != b_r[WIDTH-1])
                          && (add_sum[WIDTH-1] != a_r[WIDTH-1]);
                end
            end
            S_MUL: begin
                add_a = acc;
                add_b = q[0] ? b_r : '0;
                if (cnt == LAST_STEP) begin
                    fin      = 1'b1;
                    fin_res  = mul_q_nx;
                    fin_hi   = mul_acc_nx;
                    fin_c    = (mul_acc_nx != '0);
                    fin_v    = (mul_acc_nx != '0);
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign fin_z = (fin_hi == '0) && (fin_res == '0);
    assign fin_n = (state == S_MUL) ? fin_hi[WIDTH-1] : fin_res[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_ADD;
            a_r       <= '0;
            b_r       <= '0;
            t_r       <= '0;
            c1_r      <= 1'b0;
            acc       <= '0;
            q         <= '0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
                acc  <= '0;
                q    <= a;
                cnt  <= '0;
            end
            if (state == S_NEGB) begin
                t_r  <= add_sum;
                c1_r <= add_cout;
            end
            if (state == S_MUL) begin
                acc <= mul_acc_nx;
                q   <= mul_q_nx;
                cnt <= cnt + 1'b1;
            end
            if (fin) begin
                result    <= fin_res;
                result_hi <= fin_hi;
                flag_c    <= fin_c;
                flag_v    <= fin_v;
                flag_z    <= fin_z;
                flag_n    <= fin_n;
            end
            // DONE holds one settle cycle before offering the result.
            if (state == S_DONE && !out_valid) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
